// File: rtl/axi_vec_fetch.sv
// AXI4 read master: turns a vector index into one INCR burst and assembles the
// returned beats into a single library vector offered on a valid/ready port.
`ifndef CFG_VEC_WIDTH
`define CFG_VEC_WIDTH 600
`endif
`ifndef CFG_LIB_VEC_NUM
`define CFG_LIB_VEC_NUM 8
`endif

module axi_vec_fetch #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int VEC_WIDTH  = `CFG_VEC_WIDTH,
    parameter int VEC_NUM    = `CFG_LIB_VEC_NUM,
    parameter int IDX_W      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [ID_WIDTH-1:0]   AXI_ID    = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_idx,
    output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
    output logic [7:0]            M_AXI_arlen,
    output logic [2:0]            M_AXI_arsize,
    output logic [1:0]            M_AXI_arburst,
    output logic [ID_WIDTH-1:0]   M_AXI_arid,
    output logic [3:0]            M_AXI_arcache,
    output logic [1:0]            M_AXI_arlock,
    output logic [2:0]            M_AXI_arprot,
    output logic [3:0]            M_AXI_arqos,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    input  logic [ID_WIDTH-1:0]   M_AXI_rid,
    input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rlast,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready,
    output logic                  vec_valid,
    input  logic                  vec_ready,
    output logic [VEC_WIDTH-1:0]  vec_data,
    output logic                  vec_err,
    output logic                  busy
);

    localparam int SLICE_NUM = (VEC_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int BPB       = DATA_WIDTH / 8;
    localparam int STRIDE    = SLICE_NUM * BPB;
    localparam int BW        = $clog2(SLICE_NUM + 1);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(SLICE_NUM - 1);
    localparam logic [BW-1:0]  OVER_BEAT = BW'(SLICE_NUM);
    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(VEC_NUM);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_RD, S_OUT} state_t;

    state_t                r_state;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_vecValid;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [BW-1:0]         r_beat;

    logic                  w_reqFire;
    logic                  w_idxOk;
    logic                  w_beatFire;
    logic                  w_beatErr;
    logic [ADDR_WIDTH-1:0] w_reqAddr;
    logic [VEC_WIDTH-1:0]  w_vec;

    assign w_reqFire  = (r_state == S_IDLE) && req_valid;
    assign w_idxOk    = {1'b0, req_idx} < IDX_LIMIT;
    assign w_beatFire = r_rready && M_AXI_rvalid;
    assign w_reqAddr  = BASE_ADDR + ADDR_WIDTH'(req_idx) * ADDR_WIDTH'(STRIDE);
    // The beat counter saturates at OVER_BEAT, which marks every overrun beat as bad.
    assign w_beatErr  = (M_AXI_rresp != 2'b00) || (M_AXI_rid != AXI_ID) || (r_beat == OVER_BEAT);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= S_IDLE;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_vecValid <= 1'b0;
            r_err      <= 1'b0;
            r_araddr   <= '0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_idxOk) begin
                            r_araddr  <= w_reqAddr;
                            r_err     <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end else begin
                            r_err      <= 1'b1;
                            r_vecValid <= 1'b1;
                            r_state    <= S_OUT;
                        end
                    end
                end
                S_AR: begin
                    if (M_AXI_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (M_AXI_rvalid) begin
                        if (w_beatErr || (M_AXI_rlast && (r_beat < LAST_BEAT))) begin
                            r_err <= 1'b1;
                        end
                        if (M_AXI_rlast) begin
                            r_rready   <= 1'b0;
                            r_vecValid <= 1'b1;
                            r_state    <= S_OUT;
                        end else if (r_beat != OVER_BEAT) begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (vec_ready) begin
                        r_vecValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One register per slice; the top slice is trimmed so no storage exists above VEC_WIDTH.
    for (genvar s = 0; s < SLICE_NUM; s++) begin : g_slice
        localparam int LO = s * DATA_WIDTH;
        localparam int W  = ((VEC_WIDTH - LO) < DATA_WIDTH) ? (VEC_WIDTH - LO) : DATA_WIDTH;
        logic [W-1:0] r_slice;
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                r_slice <= '0;
            end else if (w_reqFire) begin
                r_slice <= '0;
            end else if (w_beatFire && (r_beat == BW'(s))) begin
                r_slice <= M_AXI_rdata[W-1:0];
            end
        end
        assign w_vec[LO +: W] = r_slice;
    end

    assign M_AXI_araddr  = r_araddr;
    assign M_AXI_arlen   = 8'(SLICE_NUM - 1);
    assign M_AXI_arsize  = 3'($clog2(BPB));
    assign M_AXI_arburst = 2'b01;
    assign M_AXI_arid    = AXI_ID;
    assign M_AXI_arcache = 4'b0011;
    assign M_AXI_arlock  = 2'b00;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arqos   = 4'b0000;
    assign M_AXI_arvalid = r_arvalid;
    assign M_AXI_rready  = r_rready;
    assign vec_valid     = r_vecValid;
    assign vec_data      = w_vec;
    assign vec_err       = r_err;
    assign req_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_vec_fetch.sv
// Bench for axi_vec_fetch: table of fetch cases against a behavioural AXI slave,
// with a scoreboard of expected vectors plus hand-written reset sequences.
module tb_axi_vec_fetch;

    localparam int DW     = 256;
    localparam int VW     = 600;
    localparam int AW     = 32;
    localparam int IW     = 4;
    localparam int XW     = 16;
    localparam int NVEC   = 8;
    localparam int SLICES = 3;

    typedef struct {
        logic [XW-1:0] idx;
        logic [AW-1:0] expAddr;
        int            arDelay;
        int            rGap;
        int            badRespBeat;
        int            badIdBeat;
        int            lastBeat;
        int            holdCycles;
        bit            reuse;
        bit            expErr;
    } vecCase_t;

    typedef struct {
        logic [VW-1:0] vec;
        bit            err;
    } sbEntry_t;

    logic          ACLK;
    logic          ARESETN;
    logic          req_valid;
    logic          req_ready;
    logic [XW-1:0] req_idx;
    logic [AW-1:0] M_AXI_araddr;
    logic [7:0]    M_AXI_arlen;
    logic [2:0]    M_AXI_arsize;
    logic [1:0]    M_AXI_arburst;
    logic [IW-1:0] M_AXI_arid;
    logic [3:0]    M_AXI_arcache;
    logic [1:0]    M_AXI_arlock;
    logic [2:0]    M_AXI_arprot;
    logic [3:0]    M_AXI_arqos;
    logic          M_AXI_arvalid;
    logic          M_AXI_arready;
    logic [IW-1:0] M_AXI_rid;
    logic [DW-1:0] M_AXI_rdata;
    logic [1:0]    M_AXI_rresp;
    logic          M_AXI_rlast;
    logic          M_AXI_rvalid;
    logic          M_AXI_rready;
    logic          vec_valid;
    logic          vec_ready;
    logic [VW-1:0] vec_data;
    logic          vec_err;
    logic          busy;

    sbEntry_t      sb[$];
    logic [DW-1:0] beats [5];
    vecCase_t      cases [8];
    int            nTests = 0;
    int            nFail  = 0;

    axi_vec_fetch #(
        .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VEC_WIDTH(VW),
        .VEC_NUM(NVEC), .IDX_W(XW), .BASE_ADDR(32'h1000), .AXI_ID(4'h0)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
        .M_AXI_arburst(M_AXI_arburst), .M_AXI_arid(M_AXI_arid), .M_AXI_arcache(M_AXI_arcache),
        .M_AXI_arlock(M_AXI_arlock), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
        .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
        .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
        .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .vec_err(vec_err), .busy(busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rndBeat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Waits (bounded) for the vector, compares it with the scoreboard head and hands it off.
    task automatic finishVec(input string tag, input int hold);
        sbEntry_t      e;
        int            n;
        bit            ok;
        logic [VW-1:0] d0;
        logic          r0;
        n = 0;
        while (!vec_valid && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        checkBit($sformatf("%s_vecValid", tag), vec_valid, 1'b1);
        if (sb.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, expected one entry", tag);
            return;
        end
        e = sb.pop_front();
        checkOutput($sformatf("%s_vecData", tag), vec_data, e.vec);
        checkBit($sformatf("%s_vecErr", tag), vec_err, e.err);
        checkBit($sformatf("%s_reqReadyOut", tag), req_ready, 1'b0);
        if (hold > 0) begin
            ok = 1'b1;
            d0 = vec_data;
            r0 = vec_err;
            for (int i = 0; i < hold; i++) begin
                @(negedge ACLK);
                if (!vec_valid || vec_data !== d0 || vec_err !== r0 || req_ready !== 1'b0) ok = 1'b0;
            end
            checkBit($sformatf("%s_holdStable", tag), ok, 1'b1);
        end
        vec_ready = 1'b1;
        @(negedge ACLK);
        vec_ready = 1'b0;
        checkBit($sformatf("%s_vecDrop", tag), vec_valid, 1'b0);
        checkBit($sformatf("%s_reqReadyBack", tag), req_ready, 1'b1);
    endtask

    task automatic applyStimulus(input int id, input vecCase_t c);
        string                tag;
        sbEntry_t             e;
        logic [SLICES*DW-1:0] expVecBuf;
        bit                   ok;
        int                   n;
        tag = $sformatf("case%0d", id);
        if (!c.reuse) for (int k = 0; k < 5; k++) beats[k] = rndBeat();
        expVecBuf = '0;
        if (int'(c.idx) < NVEC) begin
            for (int k = 0; k < SLICES; k++) if (k <= c.lastBeat) expVecBuf[k*DW +: DW] = beats[k];
        end
        e.vec = expVecBuf[VW-1:0];
        e.err = c.expErr;
        sb.push_back(e);

        checkBit($sformatf("%s_reqReady", tag), req_ready, 1'b1);
        req_idx   = c.idx;
        req_valid = 1'b1;
        @(negedge ACLK);
        req_valid = 1'b0;
        checkBit($sformatf("%s_busy", tag), busy, 1'b1);

        if (int'(c.idx) < NVEC) begin
            checkBit($sformatf("%s_arvalid", tag), M_AXI_arvalid, 1'b1);
            checkOutput($sformatf("%s_araddr", tag), VW'(M_AXI_araddr), VW'(c.expAddr));
            ok = 1'b1;
            M_AXI_arready = 1'b0;
            for (int i = 0; i < c.arDelay; i++) begin
                @(negedge ACLK);
                if (M_AXI_arvalid !== 1'b1 || M_AXI_araddr !== c.expAddr) ok = 1'b0;
            end
            checkBit($sformatf("%s_arHold", tag), ok, 1'b1);
            n = 0;
            while (!M_AXI_arvalid && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            M_AXI_arready = 1'b1;
            @(negedge ACLK);
            M_AXI_arready = 1'b0;

            ok = 1'b1;
            for (int k = 0; k <= c.lastBeat; k++) begin
                for (int g = 0; g < c.rGap; g++) begin
                    M_AXI_rvalid = 1'b0;
                    @(negedge ACLK);
                    if (M_AXI_arvalid) ok = 1'b0;
                end
                M_AXI_rvalid = 1'b1;
                M_AXI_rdata  = beats[k];
                M_AXI_rresp  = (k == c.badRespBeat) ? 2'b10 : 2'b00;
                M_AXI_rid    = (k == c.badIdBeat) ? 4'h5 : 4'h0;
                M_AXI_rlast  = (k == c.lastBeat);
                if (M_AXI_rready !== 1'b1 || M_AXI_arvalid) ok = 1'b0;
                @(negedge ACLK);
            end
            M_AXI_rvalid = 1'b0;
            M_AXI_rlast  = 1'b0;
            M_AXI_rresp  = 2'b00;
            M_AXI_rid    = 4'h0;
            checkBit($sformatf("%s_rPhase", tag), ok, 1'b1);
        end else begin
            checkBit($sformatf("%s_noAr", tag), M_AXI_arvalid, 1'b0);
        end
        checkBit($sformatf("%s_latency", tag), vec_valid, 1'b1);
        finishVec(tag, c.holdCycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecCase_t post;
        //             idx       expAddr   arD gap resp id last hold reuse err
        cases[0] = '{16'd2,    32'h10C0, 0,  0,  -1,  -1, 2,   0,   1'b0, 1'b0};
        cases[1] = '{16'd2,    32'h10C0, 5,  1,  -1,  -1, 2,   0,   1'b1, 1'b0};
        cases[2] = '{16'd2,    32'h10C0, 0,  0,  1,   -1, 2,   2,   1'b0, 1'b1};
        cases[3] = '{16'd5,    32'h11E0, 0,  0,  -1,  -1, 1,   0,   1'b0, 1'b1};
        cases[4] = '{16'd7,    32'h12A0, 2,  0,  -1,  0,  2,   0,   1'b0, 1'b1};
        cases[5] = '{16'd0,    32'h1000, 0,  2,  -1,  -1, 4,   0,   1'b0, 1'b1};
        cases[6] = '{16'd8,    32'h0,    0,  0,  -1,  -1, 0,   4,   1'b0, 1'b1};
        cases[7] = '{16'hFFFF, 32'h0,    0,  0,  -1,  -1, 0,   0,   1'b0, 1'b1};
        post     = '{16'd3,    32'h1120, 0,  0,  -1,  -1, 2,   0,   1'b0, 1'b0};

        ARESETN = 1'b0;
        req_valid = 1'b0;
        req_idx = '0;
        M_AXI_arready = 1'b0;
        M_AXI_rid = '0;
        M_AXI_rdata = '0;
        M_AXI_rresp = 2'b00;
        M_AXI_rlast = 1'b0;
        M_AXI_rvalid = 1'b0;
        vec_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        checkBit("rst_arvalid", M_AXI_arvalid, 1'b0);
        checkBit("rst_rready", M_AXI_rready, 1'b0);
        checkBit("rst_vecValid", vec_valid, 1'b0);
        checkBit("rst_vecErr", vec_err, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkOutput("rst_vecData", vec_data, '0);
        checkOutput("rst_araddr", VW'(M_AXI_araddr), '0);
        checkOutput("const_arlen", VW'(M_AXI_arlen), VW'(2));
        checkOutput("const_arsize", VW'(M_AXI_arsize), VW'(5));
        checkOutput("const_arburst", VW'(M_AXI_arburst), VW'(1));
        checkOutput("const_arcache", VW'(M_AXI_arcache), VW'(3));
        checkOutput("const_arid", VW'(M_AXI_arid), VW'(0));
        checkOutput("const_others", VW'({M_AXI_arlock, M_AXI_arprot, M_AXI_arqos}), VW'(0));
        ARESETN = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 8; i++) applyStimulus(i, cases[i]);

        // Reset in the middle of the data phase, after one beat has already landed.
        req_idx   = 16'd1;
        req_valid = 1'b1;
        @(negedge ACLK);
        req_valid = 1'b0;
        M_AXI_arready = 1'b1;
        @(negedge ACLK);
        M_AXI_arready = 1'b0;
        M_AXI_rvalid  = 1'b1;
        M_AXI_rdata   = rndBeat();
        @(negedge ACLK);
        M_AXI_rvalid  = 1'b0;
        checkBit("mid_busy", busy, 1'b1);
        #2 ARESETN = 1'b0;
        #1;
        checkBit("mid_arvalid", M_AXI_arvalid, 1'b0);
        checkBit("mid_rready", M_AXI_rready, 1'b0);
        checkBit("mid_vecValid", vec_valid, 1'b0);
        checkBit("mid_vecErr", vec_err, 1'b0);
        checkBit("mid_idle", busy, 1'b0);
        checkBit("mid_reqReady", req_ready, 1'b1);
        checkOutput("mid_vecData", vec_data, '0);
        checkOutput("mid_araddr", VW'(M_AXI_araddr), '0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        applyStimulus(8, post);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/axi_vec_fetch.md
Name: axi_vec_fetch

Overview:
- AXI4 read master that fetches one library vector per request from the DDR3 read slave.
- Converts a vector index into a single INCR burst of SLICE_NUM beats and assembles the beats into a VEC_WIDTH register.
- Presents the assembled vector with a valid/ready handshake to the matching datapath.
- Read-only: no write-channel ports exist on this block.

Parameters:
- ID_WIDTH, 4, AXI ID width
- DATA_WIDTH, 256, AXI data width; power of two, at least 8
- ADDR_WIDTH, 32, AXI byte-address width
- VEC_WIDTH, `CFG_VEC_WIDTH, bits per library vector
- VEC_NUM, `CFG_LIB_VEC_NUM, number of vectors in the library
- IDX_W, 16, req_idx width
- BASE_ADDR, 0, byte address of vector 0; must be beat-aligned
- AXI_ID, 0, constant ARID value driven on every burst
- Derived: SLICE_NUM = ceil(VEC_WIDTH/DATA_WIDTH), which must be ≤ 256; BPB = DATA_WIDTH/8; STRIDE = SLICE_NUM*BPB.

Ports:
- ACLK in 1: clock
- ARESETN in 1: asynchronous active-low reset
- req_valid in 1: fetch request
- req_ready out 1: request accepted when high together with req_valid
- req_idx in IDX_W: vector index
- M_AXI_araddr out ADDR_WIDTH: burst address
- M_AXI_arlen out 8: SLICE_NUM-1
- M_AXI_arsize out 3: log2(BPB)
- M_AXI_arburst out 2: 2'b01 (INCR)
- M_AXI_arid out ID_WIDTH: AXI_ID
- M_AXI_arcache/arlock/arprot/arqos out 4/2/3/4: constants 4'b0011/0/0/0
- M_AXI_arvalid out 1: address valid
- M_AXI_arready in 1: address ready
- M_AXI_rid in ID_WIDTH: read ID
- M_AXI_rdata in DATA_WIDTH: read data
- M_AXI_rresp in 2: read response
- M_AXI_rlast in 1: last beat
- M_AXI_rvalid in 1: data valid
- M_AXI_rready out 1: data ready
- vec_valid out 1: assembled vector valid
- vec_ready in 1: consumer ready
- vec_data out VEC_WIDTH: assembled vector
- vec_err out 1: error flag for this vector
- busy out 1: high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; arvalid, rready, vec_valid, vec_err = 0; vec_data, araddr = 0; beat counter = 0. Constant AR fields are unaffected by reset.
- FSM states: IDLE, AR, RD, OUT.
- IDLE: req_ready=1.
  - On req handshake with req_idx < VEC_NUM: latch araddr = BASE_ADDR + req_idx*STRIDE (mod 2^ADDR_WIDTH), clear vec_data and err, go to AR.
  - If req_idx ≥ VEC_NUM: no AXI traffic; vec_data=0, vec_err=1, go directly to OUT.
- AR: arvalid=1 from the cycle after request acceptance. araddr is held stable until the arvalid&&arready handshake, then go to RD. Dropping arvalid before handshake is forbidden.
- RD: rready=1. Each rvalid&&rready beat k writes vec_data[k*DATA_WIDTH +: DATA_WIDTH]; bits at or above VEC_WIDTH are discarded.
  - Set err if rresp != 2'b00.
  - Set err if rid != AXI_ID.
  - Early rlast (k < SLICE_NUM-1): set err and go to OUT; unfilled slices stay 0.
  - Beats past index SLICE_NUM-1 without rlast: set err, discard the data, keep rready=1 until rlast, then go to OUT.
  - Normal completion: rlast on k = SLICE_NUM-1 → OUT.
- OUT: vec_valid=1 starting the cycle after the final beat. vec_data and vec_err are stable until vec_ready. On handshake go to IDLE; req_ready rises the next cycle.
- Only one burst is outstanding at a time. req_ready=0 in AR, RD and OUT. rready=0 outside RD.
- Latency with zero stalls: request at cycle 0 → arvalid at cycle 1 → (arready immediately, slave latency L) → vec_valid one cycle after the last beat.
- Slave backpressure (arready low, rvalid gaps) stalls the FSM with no state loss.
- Reset mid-burst: returns to IDLE immediately. Outstanding R beats after reset release are the slave's responsibility; the bench resets both blocks together.

Test Plan:
- DATA_WIDTH=256, VEC_WIDTH=600 (SLICE_NUM=3, STRIDE=96), BASE_ADDR=0x1000, req_idx=2 → araddr=0x10C0, arlen=2, arsize=5, arburst=1. 3 OKAY beats → vec_data = {beat2[87:0], beat1, beat0}, vec_err=0.
- Same config, arready held low 5 cycles and rvalid toggled every other cycle → araddr stable throughout, single AR handshake, identical vec_data.
- rresp=2'b10 on beat 1 → vec_err=1, all 3 slices captured.
- rlast on beat 1 of 3 → vec_valid one cycle later, vec_err=1, slice 2 = 0.
- req_idx = VEC_NUM → no arvalid, vec_valid with vec_data=0 and vec_err=1. vec_ready held low 4 cycles → outputs stable, req_ready=0 until the cycle after the handshake.
- ARESETN pulsed low during RD → all outputs 0 asynchronously. A new request after release completes normally.
